// File: rtl/demux1x9_reg.sv
// Registered 1-to-9 write distributor: one producer, nine holding registers,
// each with a valid/ack handshake, plus slot occupancy tracking for stall control.
module demux1x9_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [WIDTH-1:0] out8,
    output logic [8:0]       out_valid,
    input  logic [8:0]       out_ack,
    output logic [3:0]       occupancy,
    output logic             full,
    output logic             empty
);

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 9; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

    logic [WIDTH-1:0] data_q [0:8];
    logic [8:0]       valid_q;
    logic [8:0]       valid_d;
    logic [3:0]       occ_q;
    logic [3:0]       occ_d;
    logic             full_q;
    logic             empty_q;
    logic [3:0]       idx_s;
    logic [8:0]       idx_oh_s;
    logic [8:0]       ack_eff_s;
    logic             ready_s;
    logic             wr_s;

    // Slot decode, readiness and next-state for valid bits and occupancy
    always_comb begin
        idx_s     = 4'd0;
        idx_oh_s  = 9'd0;
        ready_s   = 1'b0;
        wr_s      = 1'b0;
        ack_eff_s = 9'd0;
        valid_d   = valid_q;
        occ_d     = occ_q;

        // Every select value 8..15 aliases onto the last slot
        if (sel[3]) begin
            idx_s = 4'd8;
        end else begin
            idx_s = sel;
        end
        idx_oh_s  = 9'd1 << idx_s;
        ready_s   = ~valid_q[idx_s] | out_ack[idx_s];
        wr_s      = in_valid & ready_s;
        ack_eff_s = out_ack & valid_q;

        // A write overrides a same-cycle ack on its slot
        if (wr_s) begin
            valid_d = (valid_q & ~ack_eff_s) | idx_oh_s;
        end else begin
            valid_d = valid_q & ~ack_eff_s;
        end
        occ_d = occ_q + {3'b000, wr_s} - popcount9(ack_eff_s);
    end

    // Holding registers: loaded only on an accepted write, never cleared by ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 9; k++) begin
                data_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            if (wr_s) begin
                data_q[idx_s] <= in_data;
            end
        end
    end

    // Valid bits, occupancy and its full/empty decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 9'd0;
            occ_q   <= 4'd0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            full_q  <= (occ_d == 4'd9);
            empty_q <= (occ_d == 4'd0);
        end
    end

    assign in_ready  = ready_s;
    assign out_valid = valid_q;
    assign occupancy = occ_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign out0      = data_q[0];
    assign out1      = data_q[1];
    assign out2      = data_q[2];
    assign out3      = data_q[3];
    assign out4      = data_q[4];
    assign out5      = data_q[5];
    assign out6      = data_q[6];
    assign out7      = data_q[7];
    assign out8      = data_q[8];

endmodule

// File: tb/tb_demux1x9_reg.sv
// Directed self-checking bench for demux1x9_reg: fill, aliasing/stall,
// same-slot write+ack, multi-ack, spurious ack, mid-cycle reset.
module tb_demux1x9_reg;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] outs [0:8];
    logic [8:0]  out_valid;
    logic [8:0]  out_ack;
    logic [3:0]  occupancy;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;

    demux1x9_reg #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .out0(outs[0]), .out1(outs[1]), .out2(outs[2]), .out3(outs[3]),
        .out4(outs[4]), .out5(outs[5]), .out6(outs[6]), .out7(outs[7]),
        .out8(outs[8]), .out_valid(out_valid), .out_ack(out_ack),
        .occupancy(occupancy), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = 32'd0;
        sel      = 4'd0;
        in_valid = 1'b0;
        out_ack  = 9'd0;
        #2;
        chk("rst_valid", {23'd0, out_valid}, 32'd0);
        chk("rst_occ", {28'd0, occupancy}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_out4", outs[4], 32'd0);
        for (int s = 0; s < 16; s += 5) begin
            sel = 4'(s);
            #1;
            chk("rst_ready", {31'd0, in_ready}, 32'd1);
        end
        tick();
        reset = 1'b0;

        // Spurious ack on an empty block
        out_ack = 9'h1FF;
        tick();
        out_ack = 9'd0;
        chk("spur_occ", {28'd0, occupancy}, 32'd0);
        chk("spur_empty", {31'd0, empty}, 32'd1);
        chk("spur_valid", {23'd0, out_valid}, 32'd0);

        // Fill all nine slots, no acks
        for (int k = 0; k < 9; k++) begin
            sel      = 4'(k);
            in_data  = 32'hA5A5_0000 + 32'(k);
            in_valid = 1'b1;
            #1;
            chk("fill_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk("fill_data", outs[k], 32'hA5A5_0000 + 32'(k));
            chk("fill_vbit", {31'd0, out_valid[k]}, 32'd1);
            chk("fill_occ", {28'd0, occupancy}, 32'(k + 1));
        end
        in_valid = 1'b0;
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_empty", {31'd0, empty}, 32'd0);
        chk("fill_valid", {23'd0, out_valid}, 32'h1FF);

        // Multi-ack on slots 0, 4, 8
        out_ack = 9'h111;
        tick();
        out_ack = 9'd0;
        chk("mack_valid", {23'd0, out_valid}, 32'h0EE);
        chk("mack_occ", {28'd0, occupancy}, 32'd6);
        chk("mack_full", {31'd0, full}, 32'd0);
        chk("mack_out0", outs[0], 32'hA5A5_0000);
        chk("mack_out4", outs[4], 32'hA5A5_0004);
        chk("mack_out8", outs[8], 32'hA5A5_0008);

        // Slot 3 set to 0x11, then same-cycle write 0x22 + ack
        out_ack = 9'h008;
        tick();
        out_ack = 9'd0;
        chk("s3_ack_occ", {28'd0, occupancy}, 32'd5);
        sel      = 4'd3;
        in_data  = 32'h11;
        in_valid = 1'b1;
        tick();
        chk("s3_w11", outs[3], 32'h11);
        chk("s3_occ6", {28'd0, occupancy}, 32'd6);
        in_data = 32'h22;
        #1;
        chk("s3_noack_ready", {31'd0, in_ready}, 32'd0);
        out_ack = 9'h008;
        #1;
        chk("s3_ack_ready", {31'd0, in_ready}, 32'd1);
        tick();
        out_ack  = 9'd0;
        in_valid = 1'b0;
        chk("s3_data", outs[3], 32'h22);
        chk("s3_vbit", {31'd0, out_valid[3]}, 32'd1);
        chk("s3_occ", {28'd0, occupancy}, 32'd6);

        // Select aliasing onto slot 8, then stall on a different alias
        sel      = 4'hF;
        in_data  = 32'h1234;
        in_valid = 1'b1;
        tick();
        chk("alias_out8", outs[8], 32'h1234);
        chk("alias_v8", {31'd0, out_valid[8]}, 32'd1);
        chk("alias_occ", {28'd0, occupancy}, 32'd7);
        sel     = 4'h9;
        in_data = 32'hDEAD;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("stall_out8", outs[8], 32'h1234);
            chk("stall_occ", {28'd0, occupancy}, 32'd7);
        end
        in_valid = 1'b0;

        // Drop to 5 valid slots (3,5,6,7,8), stall on slot 5, reset mid-cycle
        out_ack = 9'h006;
        tick();
        out_ack = 9'd0;
        chk("pre_rst_valid", {23'd0, out_valid}, 32'h1E8);
        chk("pre_rst_occ", {28'd0, occupancy}, 32'd5);
        sel      = 4'd5;
        in_data  = 32'hBEEF;
        in_valid = 1'b1;
        #1;
        chk("pre_rst_ready", {31'd0, in_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_valid", {23'd0, out_valid}, 32'd0);
        chk("mrst_occ", {28'd0, occupancy}, 32'd0);
        chk("mrst_empty", {31'd0, empty}, 32'd1);
        chk("mrst_out3", outs[3], 32'd0);
        chk("mrst_out8", outs[8], 32'd0);
        tick();
        chk("mrst_nowrite", outs[5], 32'd0);
        chk("mrst_nowrite_v", {23'd0, out_valid}, 32'd0);
        #3;
        reset    = 1'b0;
        in_valid = 1'b0;

        // Normal writes resume; continuously acked slot takes back-to-back writes
        sel      = 4'd2;
        in_data  = 32'h55;
        in_valid = 1'b1;
        tick();
        chk("resume_out2", outs[2], 32'h55);
        chk("resume_occ", {28'd0, occupancy}, 32'd1);
        out_ack = 9'h004;
        for (int b = 0; b < 3; b++) begin
            in_data = 32'h60 + 32'(b);
            #1;
            chk("b2b_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk("b2b_data", outs[2], 32'h60 + 32'(b));
            chk("b2b_occ", {28'd0, occupancy}, 32'd1);
        end
        out_ack  = 9'd0;
        in_valid = 1'b0;
        tick();
        chk("end_occ", {28'd0, occupancy}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
